regfile_sb: RTL and testbench

- Parametrised successor to the core's register file, with two combinational read ports and one synchronous write port.
- Adds configurable width and depth, an optional hardwired-zero register 0, and optional write-to-read bypass.
- Adds a per-register busy scoreboard plus a pending-write counter, so the pipeline controller can detect RAW hazards and stall.
- Sits between decode (reads, busy set) and writeback (write, busy clear).

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_sb_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 80 ++++++++
 rtl/regfile_sb.sv | 78 +++++++
 tb/tb_regfile_sb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Default widths match the base core configuration.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;

    typedef logic [DEF_ADDR_W-1:0] idx_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the register file.
// The master side drives indices, write data and scoreboard commands.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic [ADDR_W-1:0] rna;
    logic [ADDR_W-1:0] rnb;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [ADDR_W-1:0] wn;
    logic [DATA_W-1:0] d;
    logic              we;
    logic              bsy_set;
    logic [ADDR_W-1:0] bsy_rn;
    logic              bsy_flush;
    logic              busy_a;
    logic              busy_b;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output rna, rnb, wn, d, we, bsy_set, bsy_rn, bsy_flush,
        input  qa, qb, busy_a, busy_b, pend_cnt
    );

    modport slave (
        input  rna, rnb, wn, d, we, bsy_set, bsy_rn, bsy_flush,
        output qa, qb, busy_a, busy_b, pend_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with flush < write-clear < issue-set priority.
// pend_cnt tracks the popcount incrementally; busy outputs are combinational.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wn,
    input  logic              bsy_set,
    input  logic [ADDR_W-1:0] bsy_rn,
    input  logic              bsy_flush,
    input  logic [ADDR_W-1:0] rna,
    input  logic [ADDR_W-1:0] rnb,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_nxt;
    logic             set_ok;
    logic             inc;
    logic             dec;

    always_comb begin
        set_ok   = bsy_set && !(ZERO_REG && (bsy_rn == ADDR_W'(ZERO_IDX)));
        busy_nxt = bsy_flush ? '0 : busy_q;
        if (we) begin
            busy_nxt[wn] = 1'b0;
        end
        if (set_ok) begin
            busy_nxt[bsy_rn] = 1'b1;
        end

        // A set and a clear landing on the same busy bit cancel out.
        inc = set_ok && !busy_q[bsy_rn];
        dec = we && busy_q[wn] && !(set_ok && (bsy_rn == wn));

        if (bsy_flush) begin
            cnt_nxt = {{ADDR_W{1'b0}}, set_ok};
        end else if (inc && !dec) begin
            cnt_nxt = cnt_q + (ADDR_W+1)'(1);
        end else if (dec && !inc) begin
            cnt_nxt = cnt_q - (ADDR_W+1)'(1);
        end else begin
            cnt_nxt = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

    // A same-cycle write to the source retires the hazard it would report.
    assign busy_a   = busy_q[rna] && !(BYPASS && we && (wn == rna));
    assign busy_b   = busy_q[rnb] && !(BYPASS && we && (wn == rnb));
    assign pend_cnt = cnt_q;

    a_cnt_matches: assert property (@(posedge clk) disable iff (clr)
        cnt_q == (ADDR_W+1)'($countones(busy_q)));

    a_zero_never_busy: assert property (@(posedge clk) disable iff (clr)
        !(ZERO_REG && busy_q[0]));

endmodule

// File: rtl/regfile_sb.sv
// Two combinational read ports, one synchronous write port, optional bypass.
// Busy scoreboard reports RAW hazards; the block never stalls on its own.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    regfile_sb_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              fwd;
    logic [DATA_W-1:0] qa_int;
    logic [DATA_W-1:0] qb_int;

    assign wr_ok = bus.we && !(ZERO_REG && (bus.wn == ADDR_W'(ZERO_IDX)));
    // Reset must win over forwarding so reads are 0 while clr is high.
    assign fwd   = BYPASS && wr_ok && !clr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[bus.wn] <= bus.d;
        end
    end

    always_comb begin
        if (ZERO_REG && (bus.rna == ADDR_W'(ZERO_IDX))) begin
            qa_int = '0;
        end else if (fwd && (bus.wn == bus.rna)) begin
            qa_int = bus.d;
        end else begin
            qa_int = mem[bus.rna];
        end

        if (ZERO_REG && (bus.rnb == ADDR_W'(ZERO_IDX))) begin
            qb_int = '0;
        end else if (fwd && (bus.wn == bus.rnb)) begin
            qb_int = bus.d;
        end else begin
            qb_int = mem[bus.rnb];
        end
    end

    assign bus.qa = qa_int;
    assign bus.qb = qb_int;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk       (clk),
        .clr       (clr),
        .we        (bus.we),
        .wn        (bus.wn),
        .bsy_set   (bus.bsy_set),
        .bsy_rn    (bus.bsy_rn),
        .bsy_flush (bus.bsy_flush),
        .rna       (bus.rna),
        .rnb       (bus.rnb),
        .busy_a    (bus.busy_a),
        .busy_b    (bus.busy_b),
        .pend_cnt  (bus.pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Drives two configurations (k=0: zero reg + bypass, k=1: neither) with the
// same stimulus and checks both against an array-based reference model.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  rna, rnb, wn, bsy_rn;
    logic [31:0] d;
    logic        we, bsy_set, bsy_flush;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_z ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    assign bus_z.rna = rna;  assign bus_n.rna = rna;
    assign bus_z.rnb = rnb;  assign bus_n.rnb = rnb;
    assign bus_z.wn = wn;    assign bus_n.wn = wn;
    assign bus_z.d = d;      assign bus_n.d = d;
    assign bus_z.we = we;    assign bus_n.we = we;
    assign bus_z.bsy_set = bsy_set;      assign bus_n.bsy_set = bsy_set;
    assign bus_z.bsy_rn = bsy_rn;        assign bus_n.bsy_rn = bsy_rn;
    assign bus_z.bsy_flush = bsy_flush;  assign bus_n.bsy_flush = bsy_flush;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
        u_dut_z (.clk(clk), .clr(clr), .bus(bus_z));
    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0))
        u_dut_n (.clk(clk), .clr(clr), .bus(bus_n));

    wire [31:0] qa_o [2];
    wire [31:0] qb_o [2];
    wire        ba_o [2];
    wire        bb_o [2];
    wire [5:0]  pc_o [2];
    assign qa_o[0] = bus_z.qa;        assign qa_o[1] = bus_n.qa;
    assign qb_o[0] = bus_z.qb;        assign qb_o[1] = bus_n.qb;
    assign ba_o[0] = bus_z.busy_a;    assign ba_o[1] = bus_n.busy_a;
    assign bb_o[0] = bus_z.busy_b;    assign bb_o[1] = bus_n.busy_b;
    assign pc_o[0] = bus_z.pend_cnt;  assign pc_o[1] = bus_n.pend_cnt;

    // ---------------- reference model ----------------
    bit          m_zero [2] = '{1'b1, 1'b0};
    bit          m_byp  [2] = '{1'b1, 1'b0};
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    function automatic void m_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                m_reg[k][i]  = '0;
                m_busy[k][i] = 1'b0;
            end
    endfunction

    function automatic void m_edge();
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                for (int i = 0; i < 32; i++) begin
                    m_reg[k][i] = '0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (we && !(m_zero[k] && wn == 0)) m_reg[k][wn] = d;
                if (bsy_flush)
                    for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
                if (we) m_busy[k][wn] = 1'b0;
                if (bsy_set && !(m_zero[k] && bsy_rn == 0)) m_busy[k][bsy_rn] = 1'b1;
            end
        end
    endfunction

    function automatic logic [31:0] m_q(int k, int rn);
        if (clr) return '0;
        if (m_zero[k] && rn == 0) return '0;
        if (m_byp[k] && we && int'(wn) == rn && !(m_zero[k] && wn == 0)) return d;
        return m_reg[k][rn];
    endfunction

    function automatic logic m_b(int k, int rn);
        if (clr) return 1'b0;
        return m_busy[k][rn] && !(m_byp[k] && we && int'(wn) == rn);
    endfunction

    function automatic logic [5:0] m_cnt(int k);
        int c = 0;
        if (clr) return '0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[k][i]);
        return 6'(c);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        we = 0; bsy_set = 0; bsy_flush = 0;
        wn = 0; bsy_rn = 0; d = 0; rna = 0; rnb = 0;
    endtask

    task automatic flush_all();
        idle();
        bsy_flush = 1;
        tick();
        bsy_flush = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1;
        idle();
        m_reset();
        tick();
        rna = 5'd12; rnb = 5'd12; wn = 5'd12; we = 1; d = 32'h1234_5678;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (qa_o[k] !== 32'h0 || qb_o[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_q u%0d: got %h/%h want 0", k, qa_o[k], qb_o[k]);
            end
            n_cmp++;
            if (ba_o[k] !== 1'b0 || bb_o[k] !== 1'b0 || pc_o[k] !== 6'd0) begin
                n_bad++;
                $display("FAIL reset_busy u%0d: got %b/%b cnt %0d want 0", k, ba_o[k], bb_o[k], pc_o[k]);
            end
        end
        idle();
        tick();
        clr = 0;
        tick();
    endtask

    task automatic test_write_read();
        idle();
        we = 1; wn = 5'd3; d = 32'hDEADBEEF; rnb = 5'd3;
        #1;
        n_cmp++;
        if (qb_o[0] !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL bypass_qb u0: got %h want deadbeef", qb_o[0]);
        end
        n_cmp++;
        if (qb_o[1] !== m_q(1, 3)) begin
            n_bad++;
            $display("FAIL nobypass_qb u1: got %h want %h", qb_o[1], m_q(1, 3));
        end
        tick();
        idle();
        rna = 5'd3;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (qa_o[k] !== 32'hDEADBEEF) begin
                n_bad++;
                $display("FAIL write_read u%0d: got %h want deadbeef", k, qa_o[k]);
            end
        end
    endtask

    task automatic test_zero_reg();
        flush_all();
        we = 1; wn = 5'd0; d = 32'hFFFFFFFF;
        tick();
        idle();
        rna = 5'd0;
        #1;
        n_cmp++;
        if (qa_o[0] !== 32'h0) begin
            n_bad++;
            $display("FAIL zero_read u0: got %h want 0", qa_o[0]);
        end
        n_cmp++;
        if (qa_o[1] !== 32'hFFFFFFFF) begin
            n_bad++;
            $display("FAIL plain_r0 u1: got %h want ffffffff", qa_o[1]);
        end
        bsy_set = 1; bsy_rn = 5'd0;
        tick();
        idle();
        #1;
        n_cmp++;
        if (pc_o[0] !== 6'd0 || pc_o[1] !== 6'd1) begin
            n_bad++;
            $display("FAIL zero_busy: got cnt %0d/%0d want 0/1", pc_o[0], pc_o[1]);
        end
    endtask

    task automatic test_hazard();
        flush_all();
        bsy_set = 1; bsy_rn = 5'd5;
        tick();
        idle();
        rna = 5'd5;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ba_o[k] !== 1'b1 || pc_o[k] !== 6'd1) begin
                n_bad++;
                $display("FAIL hazard_set u%0d: got busy %b cnt %0d want 1/1", k, ba_o[k], pc_o[k]);
            end
        end
        we = 1; wn = 5'd5; d = $urandom;
        #1;
        n_cmp++;
        if (ba_o[0] !== 1'b0 || ba_o[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL hazard_hide: got %b/%b want 0/1", ba_o[0], ba_o[1]);
        end
        tick();
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (pc_o[k] !== 6'd0) begin
                n_bad++;
                $display("FAIL hazard_clear u%0d: got cnt %0d want 0", k, pc_o[k]);
            end
        end
    endtask

    task automatic test_simultaneous();
        flush_all();
        bsy_set = 1; bsy_rn = 5'd7;
        tick();
        we = 1; wn = 5'd7; d = $urandom; bsy_set = 1; bsy_rn = 5'd7;
        tick();
        idle();
        rna = 5'd7;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ba_o[k] !== 1'b1 || pc_o[k] !== 6'd1) begin
                n_bad++;
                $display("FAIL set_beats_clear u%0d: got busy %b cnt %0d want 1/1", k, ba_o[k], pc_o[k]);
            end
        end
        bsy_flush = 1; bsy_set = 1; bsy_rn = 5'd9;
        tick();
        idle();
        rna = 5'd9; rnb = 5'd7;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (ba_o[k] !== 1'b1 || bb_o[k] !== 1'b0 || pc_o[k] !== 6'd1) begin
                n_bad++;
                $display("FAIL flush_set u%0d: got b9 %b b7 %b cnt %0d want 1/0/1",
                         k, ba_o[k], bb_o[k], pc_o[k]);
            end
        end
    endtask

    task automatic test_full();
        flush_all();
        for (int i = 1; i < 32; i++) begin
            bsy_set = 1; bsy_rn = 5'(i);
            tick();
        end
        idle();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (pc_o[k] !== 6'd31) begin
                n_bad++;
                $display("FAIL full31 u%0d: got %0d want 31", k, pc_o[k]);
            end
        end
        bsy_set = 1; bsy_rn = 5'd0;
        tick();
        idle();
        #1;
        n_cmp++;
        if (pc_o[0] !== 6'd31 || pc_o[1] !== 6'd32) begin
            n_bad++;
            $display("FAIL full32: got %0d/%0d want 31/32", pc_o[0], pc_o[1]);
        end
        flush_all();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (pc_o[k] !== 6'd0) begin
                n_bad++;
                $display("FAIL full_flush u%0d: got %0d want 0", k, pc_o[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            we        = ($urandom_range(0, 1) == 1);
            wn        = 5'($urandom);
            d         = $urandom;
            bsy_set   = ($urandom_range(0, 9) < 4);
            bsy_rn    = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom);
            bsy_flush = ($urandom_range(0, 29) == 0);
            rna       = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom);
            rnb       = ($urandom_range(0, 3) == 0) ? bsy_rn : 5'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (qa_o[k] !== m_q(k, int'(rna)) || qb_o[k] !== m_q(k, int'(rnb))) begin
                    n_bad++;
                    $display("FAIL rand_q u%0d cyc %0d: got %h/%h want %h/%h", k, c,
                             qa_o[k], qb_o[k], m_q(k, int'(rna)), m_q(k, int'(rnb)));
                end
                n_cmp++;
                if (ba_o[k] !== m_b(k, int'(rna)) || bb_o[k] !== m_b(k, int'(rnb))) begin
                    n_bad++;
                    $display("FAIL rand_busy u%0d cyc %0d: got %b/%b want %b/%b", k, c,
                             ba_o[k], bb_o[k], m_b(k, int'(rna)), m_b(k, int'(rnb)));
                end
                n_cmp++;
                if (pc_o[k] !== m_cnt(k)) begin
                    n_bad++;
                    $display("FAIL rand_cnt u%0d cyc %0d: got %0d want %0d", k, c, pc_o[k], m_cnt(k));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 20; i++) begin
            idle();
            we = 1; wn = 5'(i); d = $urandom; bsy_set = 1; bsy_rn = 5'(i + 5);
            tick();
        end
        we = 1; wn = 5'd4; d = 32'hA5A5_A5A5;
        #3;
        clr = 1;
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i); rnb = 5'(31 - i); wn = 5'(i);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (qa_o[k] !== 32'h0 || qb_o[k] !== 32'h0 || ba_o[k] !== 1'b0 ||
                    bb_o[k] !== 1'b0 || pc_o[k] !== 6'd0) begin
                    n_bad++;
                    $display("FAIL mid_reset u%0d idx %0d: got %h/%h %b/%b cnt %0d want all 0",
                             k, i, qa_o[k], qb_o[k], ba_o[k], bb_o[k], pc_o[k]);
                end
            end
        end
        m_reset();
        idle();
        @(negedge clk);
        clr = 0;
        we = 1; wn = 5'd6; d = 32'h0BAD_F00D;
        tick();
        idle();
        rna = 5'd6; rnb = 5'd4;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (qa_o[k] !== 32'h0BAD_F00D || qb_o[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL post_reset_write u%0d: got %h/%h want 0badf00d/0", k, qa_o[k], qb_o[k]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_hazard();
        test_simultaneous();
        test_full();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
